// File: rtl/puf_ro_sampler.sv
`timescale 1ns/1ps
// Ring-oscillator PUF sampler: walks 8 oscillator pairs, counts their edges and builds a whitened 8-bit response.
// Latency: start to resp_valid is 8*(W+9) clk cycles, with W = 64 << win_sel (584 cycles for W=64).
// Backpressure: resp/resp_mask are held in DONE until resp_ack; start is ignored while busy.
//
// Ports:
//   clk, rst            system clock; asynchronous active-high reset
//   start               single-cycle request, sampled only in IDLE
//   challenge[7:0]      whitening mask, captured at accepted start
//   win_sel[1:0]        count window select, captured at accepted start
//   ro_a, ro_b          oscillator outputs of the selected pair (asynchronous to clk)
//   ro_en               oscillator array enable
//   pair_sel[2:0]       index of the pair being measured
//   busy                high whenever the FSM is not idle
//   resp[7:0]           response byte, valid while resp_valid
//   resp_mask[7:0]      unstable-bit flags (all zero unless PUF_MARGIN_EN)
//   resp_valid          response available
//   resp_ack            consumer accepts the response
//
// Build option: define PUF_MARGIN_EN to flag bits whose count difference is below MARGIN.

module puf_ro_sampler #(
  parameter int CNT_W  = 10,
  parameter int MARGIN = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] challenge,
  input  logic [1:0] win_sel,
  input  logic       ro_a,
  input  logic       ro_b,
  output logic       ro_en,
  output logic [2:0] pair_sel,
  output logic       busy,
  output logic [7:0] resp,
  output logic [7:0] resp_mask,
  output logic       resp_valid,
  input  logic       resp_ack
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_COUNT   = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;

  logic [7:0]       chal_q;
  logic [1:0]       win_sel_q;
  logic [2:0]       bit_idx;
  logic [2:0]       settle_cnt;
  logic [9:0]       win_cnt;
  logic [9:0]       win_len;
  logic             win_last;
  logic [7:0]       resp_q;

  // Per-input synchronizer chain: [0]=s1, [1]=s2, [2]=history (s3).
  logic [2:0]       a_sync;
  logic [2:0]       b_sync;
  logic             a_rise;
  logic             b_rise;

  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic             a_wins;

  // ------------------------------------------------------------------
  // Window length and derived flags
  // ------------------------------------------------------------------
  always_comb begin
    win_len  = 10'd64 << win_sel_q;
    win_last = (win_cnt == (win_len - 10'd1));
    a_rise   = a_sync[1] & ~a_sync[2];
    b_rise   = b_sync[1] & ~b_sync[2];
    a_wins   = (cnt_a > cnt_b);
  end

  // ------------------------------------------------------------------
  // FSM state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ------------------------------------------------------------------
  // FSM next state and state-decoded outputs
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    ro_en      = 1'b0;
    busy       = 1'b1;
    resp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        ro_en = 1'b1;
        if (settle_cnt == 3'd7) begin
          state_nxt = S_COUNT;
        end
      end
      S_COUNT: begin
        ro_en = 1'b1;
        if (win_last) begin
          state_nxt = S_COMPARE;
        end
      end
      S_COMPARE: begin
        ro_en     = 1'b1;
        state_nxt = (bit_idx == 3'd7) ? S_DONE : S_SETTLE;
      end
      S_DONE: begin
        resp_valid = 1'b1;
        if (resp_ack) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Synchronizers run freely; SETTLE gives them time to flush stale
  // history from the previous pair before counting starts.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sync <= 3'b000;
      b_sync <= 3'b000;
    end else begin
      a_sync <= {a_sync[1:0], ro_a};
      b_sync <= {b_sync[1:0], ro_b};
    end
  end

  // ------------------------------------------------------------------
  // Edge counters: cleared in SETTLE, saturate in COUNT so a long window
  // on a narrow counter ends in a tie rather than a wrapped false winner.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      case (state)
        S_SETTLE: begin
          cnt_a <= '0;
          cnt_b <= '0;
        end
        S_COUNT: begin
          if (a_rise && (cnt_a != CNT_MAX)) begin
            cnt_a <= cnt_a + CNT_ONE;
          end
          if (b_rise && (cnt_b != CNT_MAX)) begin
            cnt_b <= cnt_b + CNT_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Sequencing datapath: captured request, pair index, timers, response
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chal_q     <= 8'h00;
      win_sel_q  <= 2'd0;
      bit_idx    <= 3'd0;
      settle_cnt <= 3'd0;
      win_cnt    <= 10'd0;
      resp_q     <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            chal_q     <= challenge;
            win_sel_q  <= win_sel;
            bit_idx    <= 3'd0;
            settle_cnt <= 3'd0;
            resp_q     <= 8'h00;
          end
        end
        S_SETTLE: begin
          settle_cnt <= settle_cnt + 3'd1;
          win_cnt    <= 10'd0;
        end
        S_COUNT: begin
          win_cnt <= win_cnt + 10'd1;
        end
        S_COMPARE: begin
          // A tie leaves the raw bit at 0, so the challenge bit passes through.
          resp_q[bit_idx] <= a_wins ^ chal_q[bit_idx];
          settle_cnt      <= 3'd0;
          if (bit_idx != 3'd7) begin
            bit_idx <= bit_idx + 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign pair_sel = bit_idx;
  assign resp     = resp_q;

`ifdef PUF_MARGIN_EN
  // ------------------------------------------------------------------
  // Stability flag: a pair whose counts differ by less than MARGIN may
  // flip between evaluations, so the consumer is told to discard it.
  // ------------------------------------------------------------------
  localparam logic [CNT_W:0] MARGIN_W = (CNT_W+1)'(MARGIN);

  logic [CNT_W:0] cnt_diff;
  logic           unstable;
  logic [7:0]     mask_q;

  always_comb begin
    cnt_diff = a_wins ? ({1'b0, cnt_a} - {1'b0, cnt_b})
                      : ({1'b0, cnt_b} - {1'b0, cnt_a});
    unstable = (cnt_diff < MARGIN_W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= 8'h00;
    end else begin
      if ((state == S_IDLE) && start) begin
        mask_q <= 8'h00;
      end else if (state == S_COMPARE) begin
        mask_q[bit_idx] <= unstable;
      end
    end
  end

  assign resp_mask = mask_q;
`else
  assign resp_mask = 8'h00;
`endif

endmodule

// File: tb/tb_puf_ro_sampler.sv
`timescale 1ns/1ps
// Bench for puf_ro_sampler: a CNT_W=10 instance and a CNT_W=4 instance share all inputs;
// expected responses come from a count model pushed to a scoreboard at each start.
// Oscillator inputs are square waves toggling every N clk cycles, driven away from the clock edge.

module tb_puf_ro_sampler;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] challenge;
  logic [1:0] win_sel;
  logic       ro_a;
  logic       ro_b;
  logic       resp_ack;

  logic       ro_en,   s_ro_en;
  logic [2:0] pair_sel, s_pair_sel;
  logic       busy,    s_busy;
  logic [7:0] resp,    s_resp;
  logic [7:0] resp_mask, s_resp_mask;
  logic       resp_valid, s_resp_valid;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int a_half = 0;
  int b_half = 0;
  int ro_gen = 0;

  typedef struct packed {
    logic [7:0] resp;
    logic [7:0] mask;
    logic [7:0] sat_resp;
    logic [7:0] sat_mask;
    int         lat;
  } exp_t;

  exp_t sb_q[$];

  puf_ro_sampler #(.CNT_W(10), .MARGIN(2)) dut (
    .clk(clk), .rst(rst), .start(start), .challenge(challenge), .win_sel(win_sel),
    .ro_a(ro_a), .ro_b(ro_b), .ro_en(ro_en), .pair_sel(pair_sel), .busy(busy),
    .resp(resp), .resp_mask(resp_mask), .resp_valid(resp_valid), .resp_ack(resp_ack)
  );

  puf_ro_sampler #(.CNT_W(4), .MARGIN(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .challenge(challenge), .win_sel(win_sel),
    .ro_a(ro_a), .ro_b(ro_b), .ro_en(s_ro_en), .pair_sel(s_pair_sel), .busy(s_busy),
    .resp(s_resp), .resp_mask(s_resp_mask), .resp_valid(s_resp_valid), .resp_ack(resp_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Oscillator driver; a new ro_gen restarts both waves in phase.
  initial begin
    int ac;
    int bc;
    int seen;
    ac = 0; bc = 0; seen = 0;
    ro_a = 1'b0;
    ro_b = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (ro_gen != seen) begin
        seen = ro_gen;
        ac = 0; bc = 0;
        ro_a = 1'b0;
        ro_b = 1'b0;
      end else begin
        if (a_half > 0) begin
          ac++;
          if (ac >= a_half) begin ac = 0; ro_a = ~ro_a; end
        end
        if (b_half > 0) begin
          bc++;
          if (bc >= b_half) begin bc = 0; ro_b = ~ro_b; end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
    $fatal(1);
  end

  // Expected response from ideal edge counts over the window.
  function automatic exp_t model(input logic [7:0] ch, input logic [1:0] ws,
                                 input int ah, input int bh);
    exp_t e;
    int w, ca, cb, sa, sb;
    w  = 64 << ws;
    ca = (ah > 0) ? w / (2 * ah) : 0;
    cb = (bh > 0) ? w / (2 * bh) : 0;
    sa = (ca > 15) ? 15 : ca;
    sb = (cb > 15) ? 15 : cb;
    e.resp     = (ca > cb) ? ~ch : ch;
    e.sat_resp = (sa > sb) ? ~ch : ch;
    e.mask     = 8'h00;
    e.sat_mask = 8'h00;
`ifdef PUF_MARGIN_EN
    if ((ca - cb < 2) && (cb - ca < 2)) e.mask = 8'hFF;
    if ((sa - sb < 2) && (sb - sa < 2)) e.sat_mask = 8'hFF;
`endif
    e.lat = 8 * (w + 9);
    return e;
  endfunction

  task automatic set_ro(input int ah, input int bh);
    a_half = ah;
    b_half = bh;
    ro_gen = ro_gen + 1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] ch, input logic [1:0] ws);
    @(negedge clk);
    challenge = ch;
    win_sel   = ws;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic do_ack();
    @(negedge clk);
    resp_ack = 1'b1;
    @(posedge clk);
    #1;
    resp_ack = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits (bounded) for resp_valid; returns cycles since the accepted start, or -1.
  task automatic wait_valid(output int lat);
    int lim;
    lim = 6000;
    while (resp_valid !== 1'b1 && lim > 0) begin
      @(posedge clk);
      #1;
      lim--;
    end
    lat = (resp_valid === 1'b1) ? (cyc - start_cyc) : -1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({ro_en, pair_sel, busy, resp, resp_mask, resp_valid} !== 22'h0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h expected 000000", {ro_en, pair_sel, busy, resp, resp_mask, resp_valid});
    end
    n_checks++;
    if ({s_ro_en, s_pair_sel, s_busy, s_resp, s_resp_mask, s_resp_valid} !== 22'h0) begin
      n_errors++;
      $display("FAIL reset_outputs_sat: got %h expected 000000", {s_ro_en, s_pair_sel, s_busy, s_resp, s_resp_mask, s_resp_valid});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Baseline, whitening, swapped inputs, tie and saturation from one table.
  task automatic test_patterns();
    int         t_ah[5] = '{2, 2, 4, 2, 2};
    int         t_bh[5] = '{4, 4, 2, 2, 4};
    logic [7:0] t_ch[5] = '{8'h00, 8'hA5, 8'h00, 8'h3C, 8'h96};
    logic [1:0] t_ws[5] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd3};
    exp_t e;
    int   lat;
    for (int i = 0; i < 5; i++) begin
      set_ro(t_ah[i], t_bh[i]);
      sb_q.push_back(model(t_ch[i], t_ws[i], t_ah[i], t_bh[i]));
      do_start(t_ch[i], t_ws[i]);
      n_checks++;
      if ({busy, ro_en, pair_sel} !== 5'b11000) begin
        n_errors++;
        $display("FAIL start_accept[%0d]: busy/ro_en/pair_sel got %b expected 11000", i, {busy, ro_en, pair_sel});
      end
      if (i == 0) begin
        wait_cyc(start_cyc + 72);
        n_checks++;
        if (pair_sel !== 3'd0) begin
          n_errors++;
          $display("FAIL pair_sel_in_compare: got %0d expected 0", pair_sel);
        end
        wait_cyc(start_cyc + 73);
        n_checks++;
        if (pair_sel !== 3'd1) begin
          n_errors++;
          $display("FAIL pair_sel_after_compare: got %0d expected 1", pair_sel);
        end
      end
      wait_valid(lat);
      e = sb_q.pop_front();
      n_checks++;
      if (lat !== e.lat) begin
        n_errors++;
        $display("FAIL latency[%0d]: got %0d expected %0d", i, lat, e.lat);
      end
      n_checks++;
      if ({resp, resp_mask} !== {e.resp, e.mask}) begin
        n_errors++;
        $display("FAIL resp[%0d]: resp/mask got %h/%h expected %h/%h", i, resp, resp_mask, e.resp, e.mask);
      end
      n_checks++;
      if ({s_resp_valid, s_resp, s_resp_mask} !== {1'b1, e.sat_resp, e.sat_mask}) begin
        n_errors++;
        $display("FAIL sat_resp[%0d]: valid/resp/mask got %b/%h/%h expected 1/%h/%h", i, s_resp_valid, s_resp, s_resp_mask, e.sat_resp, e.sat_mask);
      end
      if (i == 0) begin
        n_checks++;
        if ({ro_en, pair_sel, busy} !== 5'b01111) begin
          n_errors++;
          $display("FAIL done_outputs: ro_en/pair_sel/busy got %b expected 01111", {ro_en, pair_sel, busy});
        end
      end
      do_ack();
      n_checks++;
      if ({resp_valid, busy} !== 2'b00) begin
        n_errors++;
        $display("FAIL ack_to_idle[%0d]: resp_valid/busy got %b expected 00", i, {resp_valid, busy});
      end
    end
  endtask

  task automatic test_handshake();
    exp_t e;
    int   lat;
    set_ro(2, 4);
    sb_q.push_back(model(8'h11, 2'd0, 2, 4));
    do_start(8'h11, 2'd0);
    wait_cyc(start_cyc + 20);
    // start and a stray ack during COUNT must both be ignored
    @(negedge clk);
    start     = 1'b1;
    challenge = 8'hFF;
    win_sel   = 2'd3;
    resp_ack  = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    resp_ack = 1'b0;
    n_checks++;
    if ({busy, ro_en, pair_sel} !== 5'b11000) begin
      n_errors++;
      $display("FAIL start_ignored: busy/ro_en/pair_sel got %b expected 11000", {busy, ro_en, pair_sel});
    end
    wait_cyc(start_cyc + 73);
    n_checks++;
    if (pair_sel !== 3'd1) begin
      n_errors++;
      $display("FAIL no_restart_pair: got %0d expected 1", pair_sel);
    end
    wait_valid(lat);
    e = sb_q.pop_front();
    n_checks++;
    if (lat !== e.lat) begin
      n_errors++;
      $display("FAIL handshake_latency: got %0d expected %0d", lat, e.lat);
    end
    n_checks++;
    if ({resp, resp_mask} !== {e.resp, e.mask}) begin
      n_errors++;
      $display("FAIL handshake_resp: got %h/%h expected %h/%h", resp, resp_mask, e.resp, e.mask);
    end
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ({resp_valid, resp, resp_mask} !== {1'b1, e.resp, e.mask}) begin
        n_errors++;
        $display("FAIL hold_stable[%0d]: valid/resp/mask got %b/%h/%h expected 1/%h/%h", k, resp_valid, resp, resp_mask, e.resp, e.mask);
      end
    end
    do_ack();
    n_checks++;
    if ({resp_valid, busy} !== 2'b00) begin
      n_errors++;
      $display("FAIL handshake_ack: resp_valid/busy got %b expected 00", {resp_valid, busy});
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    sb_q.push_back(model(8'hC3, 2'd0, 2, 4));
    do_start(8'hC3, 2'd0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_start: busy got %b expected 1", busy);
    end
    wait_valid(lat);
    e = sb_q.pop_front();
    n_checks++;
    if ({lat, resp, resp_mask} !== {e.lat, e.resp, e.mask}) begin
      n_errors++;
      $display("FAIL b2b_resp: lat/resp/mask got %0d/%h/%h expected %0d/%h/%h", lat, resp, resp_mask, e.lat, e.resp, e.mask);
    end
    do_ack();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   lat;
    set_ro(2, 4);
    do_start(8'h5A, 2'd0);
    wait_cyc(start_cyc + 250);
    n_checks++;
    if ({pair_sel, ro_en, busy} !== 5'b01111) begin
      n_errors++;
      $display("FAIL mid_count_bit3: pair_sel/ro_en/busy got %b expected 01111", {pair_sel, ro_en, busy});
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({ro_en, pair_sel, busy, resp, resp_mask, resp_valid} !== 22'h0) begin
      n_errors++;
      $display("FAIL async_reset: got %h expected 000000", {ro_en, pair_sel, busy, resp, resp_mask, resp_valid});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb_q.push_back(model(8'h5A, 2'd0, 2, 4));
    do_start(8'h5A, 2'd0);
    wait_valid(lat);
    e = sb_q.pop_front();
    n_checks++;
    if ({lat, resp, resp_mask} !== {e.lat, e.resp, e.mask}) begin
      n_errors++;
      $display("FAIL after_reset_resp: lat/resp/mask got %0d/%h/%h expected %0d/%h/%h", lat, resp, resp_mask, e.lat, e.resp, e.mask);
    end
    do_ack();
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    resp_ack  = 1'b0;
    challenge = 8'h00;
    win_sel   = 2'd0;
    test_reset();
    test_patterns();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
